// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c master arbiter.
//   state_e : sequencer state encoding
//   ByteW / AddrW / SizeW : data byte, slave address and byte-count widths
package i2c_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StIssue  = 2'b01,
        StActive = 2'b11,
        StDone   = 2'b10
    } state_e;

    localparam int unsigned ByteW = 8;
    localparam int unsigned AddrW = 7;
    localparam int unsigned SizeW = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req_i : request vector
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : index of the granted requester
module rr_picker #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    always_comb begin
        logic found;
        int   k;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        // Scan from the pointer upward, wrapping past N-1 back to 0.
        for (int i = 0; i < int'(N); i++) begin
            k = (int'(ptr_i) + i) % int'(N);
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master between N requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_i .. wvalid_i   : per-requester command and write data
//   grant_o .. err_o    : per-requester grant, byte handshakes and completion
//   rdata_o             : shared read byte
//   m_*                 : command/handshake interface to the i2c_master
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned WAIT_LIMIT = 4096,
    parameter int unsigned WL_W       = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_i,
    input  logic [N-1:0]       rnw_i,
    input  logic [7*N-1:0]     addr_i,
    input  logic [3*N-1:0]     size_i,
    input  logic [8*N-1:0]     wdata_i,
    input  logic [N-1:0]       wvalid_i,
    output logic [N-1:0]       grant_o,
    output logic [N-1:0]       wreq_o,
    output logic [N-1:0]       rvalid_o,
    output logic [7:0]         rdata_o,
    output logic [N-1:0]       done_o,
    output logic [N-1:0]       err_o,
    output logic               m_start,
    output logic               m_read_nwrite,
    output logic [6:0]         m_addr,
    output logic [2:0]         m_data_size,
    output logic [7:0]         m_data_i,
    output logic               m_data_valid,
    input  logic               m_ready,
    input  logic               m_busy,
    input  logic               m_data_request,
    input  logic               m_data_available,
    input  logic [7:0]         m_data_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    state_e             state_q, state_d;
    logic [N-1:0]       grant_q;
    logic [IdxW-1:0]    idx_q, ptr_q;
    logic               rnw_q;
    logic [AddrW-1:0]   addr_q;
    logic [SizeW-1:0]   size_q;
    logic               err_q;
    logic [WL_W-1:0]    wait_q;
    logic               dav_q;
    logic               rvalid_q;
    logic [ByteW-1:0]   rdata_q;

    logic [N-1:0]       pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic               dav_rise;
    logic               wait_expired;

    // A bus held by another master simply shows up as ready never dropping,
    // which the wait timeout already covers.
    logic unused_busy;
    assign unused_busy = m_busy;

    rr_picker #(
        .N    (N),
        .IdxW (IdxW)
    ) u_picker (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign dav_rise     = (state_q == StActive) && m_data_available && !dav_q;
    assign wait_expired = (wait_q == WL_W'(WAIT_LIMIT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (m_ready && |req_i) state_d = StIssue;
            // Zero-size commands are rejected here, before m_start is raised.
            StIssue: begin
                if (size_q == '0)       state_d = StDone;
                else if (!m_ready)      state_d = StActive;
                else if (wait_expired)  state_d = StDone;
            end
            StActive: if (m_ready) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Command latch, wait counter, read capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
            dav_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            dav_q    <= m_data_available;
            rvalid_q <= dav_rise;
            if (dav_rise) rdata_q <= m_data_o;
            unique case (state_q)
                StIdle: begin
                    wait_q <= '0;
                    if (state_d == StIssue) begin
                        grant_q <= pick_gnt;
                        idx_q   <= pick_idx;
                        rnw_q   <= rnw_i[pick_idx];
                        addr_q  <= addr_i[int'(pick_idx) * AddrW +: AddrW];
                        size_q  <= size_i[int'(pick_idx) * SizeW +: SizeW];
                    end
                end
                StIssue: begin
                    wait_q <= wait_q + WL_W'(1);
                    // Leaving ISSUE straight to DONE is always an abort.
                    if (state_d == StDone) err_q <= 1'b1;
                end
                StDone: begin
                    grant_q <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        grant_o       = grant_q;
        m_start       = (state_q == StIssue) && (size_q != '0);
        m_read_nwrite = rnw_q;
        m_addr        = addr_q;
        m_data_size   = size_q;
        m_data_i      = '0;
        m_data_valid  = 1'b0;
        wreq_o        = '0;
        done_o        = '0;
        err_o         = '0;
        rvalid_o      = rvalid_q ? grant_q : '0;
        rdata_o       = rdata_q;
        if (state_q == StActive) begin
            m_data_i     = wdata_i[int'(idx_q) * ByteW +: ByteW];
            m_data_valid = wvalid_i[idx_q];
            wreq_o       = m_data_request ? grant_q : '0;
        end
        if (state_q == StDone) begin
            done_o = grant_q;
            err_o  = err_q ? grant_q : '0;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter (N=2, WAIT_LIMIT=16).
module tb_i2c_master_arbiter;

    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i, rnw_i, wvalid_i;
    logic [7*N-1:0] addr_i;
    logic [3*N-1:0] size_i;
    logic [8*N-1:0] wdata_i;
    logic [N-1:0]   grant_o, wreq_o, rvalid_o, done_o, err_o;
    logic [7:0]     rdata_o;
    logic           m_start, m_read_nwrite, m_data_valid;
    logic [6:0]     m_addr;
    logic [2:0]     m_data_size;
    logic [7:0]     m_data_i;
    logic           m_ready, m_busy, m_data_request, m_data_available;
    logic [7:0]     m_data_o;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int d0 = 0, d1 = 0, rv0 = 0, rv1 = 0, st = 0;

    i2c_master_arbiter #(
        .N          (N),
        .WAIT_LIMIT (16),
        .WL_W       (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req_i),
        .rnw_i            (rnw_i),
        .addr_i           (addr_i),
        .size_i           (size_i),
        .wdata_i          (wdata_i),
        .wvalid_i         (wvalid_i),
        .grant_o          (grant_o),
        .wreq_o           (wreq_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .m_start          (m_start),
        .m_read_nwrite    (m_read_nwrite),
        .m_addr           (m_addr),
        .m_data_size      (m_data_size),
        .m_data_i         (m_data_i),
        .m_data_valid     (m_data_valid),
        .m_ready          (m_ready),
        .m_busy           (m_busy),
        .m_data_request   (m_data_request),
        .m_data_available (m_data_available),
        .m_data_o         (m_data_o)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (done_o[0])   d0  <= d0 + 1;
        if (done_o[1])   d1  <= d1 + 1;
        if (rvalid_o[0]) rv0 <= rv0 + 1;
        if (rvalid_o[1]) rv1 <= rv1 + 1;
        if (m_start)     st  <= st + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap0, snap1, snap2, cnt;
        logic [1:0] exp_g;

        rst = 1'b1;
        req_i = '0; rnw_i = '0; wvalid_i = '0;
        addr_i = '0; size_i = '0; wdata_i = '0;
        m_ready = 1'b1; m_busy = 1'b0; m_data_request = 1'b0;
        m_data_available = 1'b0; m_data_o = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_grant", 32'(grant_o), 32'h0);
        check_eq("rst_start", 32'(m_start), 32'h0);
        check_eq("rst_done", 32'(done_o), 32'h0);
        check_eq("rst_addr", 32'(m_addr), 32'h0);
        check_eq("rst_rdata", 32'(rdata_o), 32'h0);

        // Single write: requester 0, addr 0x50, 2 bytes
        req_i = 2'b01; addr_i[6:0] = 7'h50; size_i[2:0] = 3'd2;
        wdata_i[7:0] = 8'hA5; wvalid_i = 2'b01;
        step();
        check_eq("wr_grant", 32'(grant_o), 32'h1);
        check_eq("wr_start", 32'(m_start), 32'h1);
        check_eq("wr_addr", 32'(m_addr), 32'h50);
        check_eq("wr_size", 32'(m_data_size), 32'h2);
        check_eq("wr_rnw", 32'(m_read_nwrite), 32'h0);
        step();
        check_eq("wr_start_held", 32'(m_start), 32'h1);
        m_ready = 1'b0;
        step();
        check_eq("wr_start_drop", 32'(m_start), 32'h0);
        m_data_request = 1'b1; #1;
        check_eq("wr_wreq1", 32'(wreq_o), 32'h1);
        check_eq("wr_data1", 32'(m_data_i), 32'hA5);
        check_eq("wr_valid", 32'(m_data_valid), 32'h1);
        step();
        m_data_request = 1'b0; #1;
        check_eq("wr_wreq_low", 32'(wreq_o), 32'h0);
        wdata_i[7:0] = 8'h3C; m_data_request = 1'b1; #1;
        check_eq("wr_wreq2", 32'(wreq_o), 32'h1);
        check_eq("wr_data2", 32'(m_data_i), 32'h3C);
        step();
        m_data_request = 1'b0; m_ready = 1'b1; #1;
        check_eq("wr_done_early", 32'(done_o), 32'h0);
        step();
        check_eq("wr_done", 32'(done_o), 32'h1);
        check_eq("wr_err", 32'(err_o), 32'h0);
        req_i = '0; wvalid_i = '0;
        step();
        check_eq("wr_done_end", 32'(done_o), 32'h0);
        check_eq("wr_grant_end", 32'(grant_o), 32'h0);

        // Read of 3 bytes: requester 1, addr 0x68
        snap0 = rv0; snap1 = rv1;
        req_i = 2'b10; rnw_i = 2'b10; addr_i[13:7] = 7'h68; size_i[5:3] = 3'd3;
        step();
        check_eq("rd_grant", 32'(grant_o), 32'h2);
        check_eq("rd_rnw", 32'(m_read_nwrite), 32'h1);
        check_eq("rd_addr", 32'(m_addr), 32'h68);
        m_ready = 1'b0;
        step();
        for (int b = 1; b <= 3; b++) begin
            m_data_o = 8'(b * 8'h11); m_data_available = 1'b1;
            step();
            check_eq("rd_rvalid", 32'(rvalid_o), 32'h2);
            check_eq("rd_rdata", 32'(rdata_o), 32'(b * 8'h11));
            step();
            check_eq("rd_rvalid_once", 32'(rvalid_o), 32'h0);
            m_data_available = 1'b0;
            step();
        end
        m_ready = 1'b1;
        step();
        check_eq("rd_done", 32'(done_o), 32'h2);
        req_i = '0; rnw_i = '0;
        step();
        check_eq("rd_pulses1", 32'(rv1 - snap1), 32'd3);
        check_eq("rd_pulses0", 32'(rv0 - snap0), 32'd0);

        // Contention: both requesters held
        snap0 = d0; snap1 = d1;
        req_i = 2'b11; size_i = {3'd1, 3'd1};
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            check_eq("ct_grant", 32'(grant_o), 32'(exp_g));
            m_ready = 1'b0;
            step();
            m_ready = 1'b1;
            step();
            check_eq("ct_done", 32'(done_o), 32'(exp_g));
            if (t == 3) req_i = '0;
            step();
        end
        check_eq("ct_done0_cnt", 32'(d0 - snap0), 32'd2);
        check_eq("ct_done1_cnt", 32'(d1 - snap1), 32'd2);

        // Bus busy: ready never drops, abort after 16 cycles
        req_i = 2'b01; m_busy = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!m_start) break;
            cnt++;
            step();
        end
        check_eq("busy_start_cycles", 32'(cnt), 32'd16);
        check_eq("busy_done", 32'(done_o), 32'h1);
        check_eq("busy_err", 32'(err_o), 32'h1);
        m_busy = 1'b0; req_i = '0;
        step();
        check_eq("busy_err_end", 32'(err_o), 32'h0);

        // Size 0: requester 1, rejected without a start
        snap2 = st;
        req_i = 2'b10; size_i = '0;
        step();
        check_eq("sz0_grant", 32'(grant_o), 32'h2);
        check_eq("sz0_no_start", 32'(m_start), 32'h0);
        check_eq("sz0_done_early", 32'(done_o), 32'h0);
        step();
        check_eq("sz0_done", 32'(done_o), 32'h2);
        check_eq("sz0_err", 32'(err_o), 32'h2);
        req_i = '0;
        step();
        check_eq("sz0_start_cnt", 32'(st - snap2), 32'd0);

        // Reset mid-ACTIVE, then a fresh request
        req_i = 2'b01; size_i = {3'd0, 3'd2};
        step();
        m_ready = 1'b0;
        step();
        m_data_request = 1'b1; #1;
        check_eq("rs_wreq_active", 32'(wreq_o), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rs_grant", 32'(grant_o), 32'h0);
        check_eq("rs_wreq", 32'(wreq_o), 32'h0);
        check_eq("rs_start", 32'(m_start), 32'h0);
        check_eq("rs_addr", 32'(m_addr), 32'h0);
        check_eq("rs_state", 32'(dut.state_q), 32'h0);
        m_data_request = 1'b0; m_ready = 1'b1;
        step();
        check_eq("rs_regrant", 32'(grant_o), 32'h1);
        check_eq("rs_restart", 32'(m_start), 32'h1);
        m_ready = 1'b0;
        step();
        m_ready = 1'b1;
        step();
        check_eq("rs_done", 32'(done_o), 32'h1);
        check_eq("rs_err", 32'(err_o), 32'h0);
        req_i = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
